// File: rtl/cam_sccb_init_seq_if.sv
// SCCB write-controller handshake shared by the init sequencer (master)
// and the SCCB controller (slave).
interface cam_sccb_init_seq_if;
   logic        sccb_start_o;
   logic        sccb_rw_o;
   logic [15:0] sccb_data_o;
   logic        sccb_done_i;
   logic        sccb_ack_err_i;

   modport master (
      output sccb_start_o, sccb_rw_o, sccb_data_o,
      input  sccb_done_i, sccb_ack_err_i
   );

   modport slave (
      input  sccb_start_o, sccb_rw_o, sccb_data_o,
      output sccb_done_i, sccb_ack_err_i
   );
endinterface

// File: rtl/cam_sccb_init_seq.sv
// Camera register-init sequencer: walks a config ROM, issues SCCB writes with
// bounded retries, honours inline ms delays, reports done/error.
module cam_sccb_init_seq #(
   parameter int ADDR_W      = 8,
   parameter int MAX_RETRY   = 3,
   parameter int MS_CYC      = 50000,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 go_i,
   output logic [ADDR_W-1:0]    rom_addr_o,
   input  logic [15:0]          rom_data_i,
   cam_sccb_init_seq_if.master  sccb,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic [ADDR_W-1:0]    err_index_o
);

   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int SUB_W = $clog2(MS_CYC + 1);
   localparam int RT_W  = $clog2(MAX_RETRY + 2);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_XFER, S_RELEASE, S_DELAY, S_NEXT, S_DONE, S_FAIL
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  index_q, index_d;
   logic [15:0]        entry_q, entry_d;
   logic [RT_W-1:0]    retry_q, retry_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [7:0]         ms_q, ms_d;
   logic [SUB_W-1:0]   sub_q, sub_d;
   logic               err_q, err_d;
   // charged_q: the current failed attempt has already consumed its retry
   logic               charged_q, charged_d;

   logic wd_expired;
   logic retry_left;

   assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign retry_left = (retry_q < RT_W'(MAX_RETRY));

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         entry_q   <= '0;
         retry_q   <= '0;
         wd_q      <= '0;
         ms_q      <= '0;
         sub_q     <= '0;
         err_q     <= 1'b0;
         charged_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         entry_q   <= entry_d;
         retry_q   <= retry_d;
         wd_q      <= wd_d;
         ms_q      <= ms_d;
         sub_q     <= sub_d;
         err_q     <= err_d;
         charged_q <= charged_d;
      end
   end

   // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      entry_d   = entry_q;
      retry_d   = retry_q;
      wd_d      = '0;
      ms_d      = ms_q;
      sub_d     = sub_q;
      err_d     = err_q;
      charged_d = charged_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (go_i) begin
               index_d   = '0;
               retry_d   = '0;
               err_d     = 1'b0;
               charged_d = 1'b0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            entry_d = rom_data_i;
            if (rom_data_i == 16'hFFFF) begin
               state_d = S_DONE;
            end else if (rom_data_i[15:8] == 8'hFE) begin
               ms_d    = rom_data_i[7:0];
               sub_d   = '0;
               state_d = S_DELAY;
            end else if (!sccb.sccb_done_i) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (sccb.sccb_done_i) begin
               err_d     = sccb.sccb_ack_err_i;
               charged_d = 1'b0;
               state_d   = S_RELEASE;
            end else if (wd_expired) begin
               err_d     = 1'b1;
               charged_d = 1'b0;
               state_d   = S_RELEASE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_RELEASE: begin
            if (!sccb.sccb_done_i) begin
               if (!err_q) begin
                  state_d = S_NEXT;
               end else if (charged_q) begin
                  charged_d = 1'b0;
                  state_d   = S_XFER;
               end else if (retry_left) begin
                  retry_d = retry_q + RT_W'(1);
                  state_d = S_XFER;
               end else begin
                  state_d = S_FAIL;
               end
            end else if (wd_expired) begin
               // Done stuck high: charge the retry now, keep waiting for done to fall.
               err_d = 1'b1;
               if (!charged_q && retry_left) begin
                  retry_d   = retry_q + RT_W'(1);
                  charged_d = 1'b1;
               end else begin
                  state_d = S_FAIL;
               end
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_DELAY: begin
            if (ms_q == 8'd0) begin
               state_d = S_NEXT;
            end else if (sub_q == SUB_W'(MS_CYC - 1)) begin
               sub_d = '0;
               ms_d  = ms_q - 8'd1;
            end else begin
               sub_d = sub_q + SUB_W'(1);
            end
         end
         S_NEXT: begin
            retry_d = '0;
            index_d = index_q + ADDR_W'(1);
            state_d = (index_q == '1) ? S_DONE : S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rom_addr_o        = index_q;
   assign sccb.sccb_start_o = (state_q == S_XFER);
   assign sccb.sccb_rw_o    = 1'b1;
   assign sccb.sccb_data_o  = entry_q;
   assign busy_o            = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
   assign done_o            = (state_q == S_DONE);
   assign error_o           = (state_q == S_FAIL);
   assign err_index_o       = (state_q == S_FAIL) ? index_q : '0;

endmodule

// File: tb/tb_cam_sccb_init_seq.sv
// Self-checking bench for cam_sccb_init_seq: directed and random ROM tables
// against a table-walking reference model and a behavioural SCCB controller.
module tb_cam_sccb_init_seq;

   localparam int ADDR_W      = 4;
   localparam int MAX_RETRY   = 3;
   localparam int MS_CYC      = 10;
   localparam int TIMEOUT_CYC = 100;
   localparam int DEPTH       = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              go_i;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [15:0]       rom_data_i;
   logic              busy_o, done_o, error_o;
   logic [ADDR_W-1:0] err_index_o;

   cam_sccb_init_seq_if sccb_if ();

   cam_sccb_init_seq #(
      .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY), .MS_CYC(MS_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .go_i(go_i),
      .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
      .sccb(sccb_if.master),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_index_o(err_index_o)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [DEPTH];
   int          nfail [DEPTH];
   always @(posedge clk) rom_data_i <= rom[rom_addr_o];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural SCCB controller: done after lat cycles, drops done once start falls.
   bit hang;
   int lat;
   int att [DEPTH];
   int c_wait;
   bit c_act, c_fail;
   always @(negedge clk) begin
      if (rst_i) begin
         sccb_if.sccb_done_i    <= 1'b0;
         sccb_if.sccb_ack_err_i <= 1'b0;
         c_act                  <= 1'b0;
      end else begin
         if (!busy_o) foreach (att[i]) att[i] <= 0;
         if (sccb_if.sccb_done_i) begin
            if (!sccb_if.sccb_start_o) begin
               sccb_if.sccb_done_i    <= 1'b0;
               sccb_if.sccb_ack_err_i <= 1'b0;
               c_act                  <= 1'b0;
            end
         end else if (c_act) begin
            if (!sccb_if.sccb_start_o) c_act <= 1'b0;
            else if (c_wait == 0) begin
               sccb_if.sccb_done_i    <= 1'b1;
               sccb_if.sccb_ack_err_i <= c_fail;
            end else c_wait <= c_wait - 1;
         end else if (sccb_if.sccb_start_o && !hang) begin
            c_act                    <= 1'b1;
            c_wait                   <= lat;
            att[int'(rom_addr_o)]    <= att[int'(rom_addr_o)] + 1;
            c_fail                   <= (att[int'(rom_addr_o)] + 1) <= nfail[int'(rom_addr_o)];
         end
      end
   end

   // Transaction monitor: logs start pulses and protocol violations per run.
   logic [15:0] obs_q[$];
   int first_rise, hi_len, last_len, viol_start, viol_data;
   bit prev_start = 1'b0, prev_busy = 1'b0;
   logic [15:0] prev_data;
   always @(negedge clk) begin
      if (busy_o && !prev_busy) begin
         obs_q.delete();
         first_rise <= -1;
         viol_start <= 0;
         viol_data  <= 0;
      end
      if (sccb_if.sccb_start_o && !prev_start) begin
         if (sccb_if.sccb_done_i) viol_start <= viol_start + 1;
         obs_q.push_back(sccb_if.sccb_data_o);
         if (first_rise < 0) first_rise <= cyc;
         hi_len <= 1;
      end else if (sccb_if.sccb_start_o) begin
         hi_len <= hi_len + 1;
         if (sccb_if.sccb_data_o !== prev_data) viol_data <= viol_data + 1;
      end
      if (!sccb_if.sccb_start_o && prev_start) last_len <= hi_len;
      prev_start <= sccb_if.sccb_start_o;
      prev_busy  <= busy_o;
      prev_data  <= sccb_if.sccb_data_o;
   end

   // Reference model: walk the table by its rules, list the expected SCCB writes.
   logic [15:0] exp_q[$];
   bit exp_done, exp_err;
   int exp_idx;
   task automatic model();
      exp_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_idx  = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rom[i] == 16'hFFFF) begin
            exp_done = 1'b1;
            return;
         end
         if (rom[i][15:8] == 8'hFE) continue;
         if (nfail[i] > MAX_RETRY) begin
            repeat (MAX_RETRY + 1) exp_q.push_back(rom[i]);
            exp_err = 1'b1;
            exp_idx = i;
            return;
         end
         repeat (nfail[i] + 1) exp_q.push_back(rom[i]);
      end
      exp_done = 1'b1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < DEPTH; i++) begin
         rom[i]   = 16'h0000;
         nfail[i] = 0;
      end
   endtask

   function automatic logic [15:0] rand_write();
      return {8'($urandom_range(0, 253)), 8'($urandom)};
   endfunction

   int go_cyc;
   task automatic run(input int latency, input bit hang_mode, input bit go_mid, input string tag);
      int n;
      model();
      lat  = latency;
      hang = hang_mode;
      @(negedge clk);
      go_i   = 1'b1;
      go_cyc = cyc;
      @(negedge clk);
      go_i = 1'b0;
      check({tag, " fetch addr"}, rom_addr_o, 0);
      check({tag, " busy"}, busy_o, 1);
      check({tag, " done cleared"}, done_o, 0);
      check({tag, " error cleared"}, error_o, 0);
      if (go_mid) begin
         repeat (15) @(negedge clk);
         go_i = 1'b1;
         @(negedge clk);
         go_i = 1'b0;
      end
      n = 0;
      while (!(done_o || error_o) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " finished in budget"}, n < 5000, 1);
      repeat (3) @(negedge clk);
      check({tag, " start count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s start%0d data", tag, i), obs_q[i], exp_q[i]);
      check({tag, " done"}, done_o, exp_done);
      check({tag, " error"}, error_o, exp_err);
      check({tag, " busy idle"}, busy_o, 0);
      check({tag, " err_index"}, err_index_o, exp_err ? exp_idx : 0);
      check({tag, " rw"}, sccb_if.sccb_rw_o, 1);
      check({tag, " start while done"}, viol_start, 0);
      check({tag, " data stable"}, viol_data, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      rst_i = 1'b1;
      go_i  = 1'b0;
      hang  = 1'b0;
      lat   = 1;
      clear_rom();
      repeat (3) @(negedge clk);
      check("reset start", sccb_if.sccb_start_o, 0);
      check("reset busy", busy_o, 0);
      check("reset done", done_o, 0);
      check("reset error", error_o, 0);
      check("reset rom_addr", rom_addr_o, 0);
      check("reset err_index", err_index_o, 0);
      check("reset data", sccb_if.sccb_data_o, 0);
      check("reset rw", sccb_if.sccb_rw_o, 1);
      rst_i = 1'b0;

      clear_rom();
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
      run(2, 1'b0, 1'b0, "basic");

      clear_rom();
      rom[0] = 16'hFE02; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
      run(1, 1'b0, 1'b0, "delay");
      check("delay first start latency", (first_rise - go_cyc >= 22) && (first_rise - go_cyc <= 30), 1);

      clear_rom();
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
      nfail[1] = 2;
      run(1, 1'b0, 1'b0, "retry");

      clear_rom();
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h2233; rom[3] = 16'h4455; rom[4] = 16'hFFFF;
      nfail[2] = 99;
      run(0, 1'b0, 1'b1, "fatal");

      clear_rom();
      rom[0] = 16'h1280; rom[1] = 16'hFFFF;
      nfail[0] = 99;
      run(0, 1'b1, 1'b0, "timeout");
      check("timeout start width", last_len, TIMEOUT_CYC);

      clear_rom();
      for (int i = 0; i < DEPTH; i++) rom[i] = rand_write();
      run(1, 1'b0, 1'b0, "wrap");

      // Reset while the controller hangs mid-transfer, then restart cleanly.
      clear_rom();
      rom[0] = 16'h1280; rom[1] = 16'hFFFF;
      hang = 1'b1;
      @(negedge clk);
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      n = 0;
      while (!sccb_if.sccb_start_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst mid xfer reached", sccb_if.sccb_start_o, 1);
      repeat (5) @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      check("rst mid start", sccb_if.sccb_start_o, 0);
      check("rst mid busy", busy_o, 0);
      check("rst mid done", done_o, 0);
      check("rst mid error", error_o, 0);
      check("rst mid rom_addr", rom_addr_o, 0);
      check("rst mid data", sccb_if.sccb_data_o, 0);
      @(negedge clk);
      rst_i = 1'b0;
      hang  = 1'b0;
      clear_rom();
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
      run(1, 1'b0, 1'b0, "after reset");

      for (int t = 0; t < 8; t++) begin
         int len;
         clear_rom();
         for (int i = 0; i < DEPTH; i++) rom[i] = rand_write();
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r >= 10) rom[i] = {8'hFE, 8'($urandom_range(0, 2))};
            else if (r >= 9) nfail[i] = 4;
            else if (r >= 7) nfail[i] = $urandom_range(1, 2);
         end
         rom[len] = 16'hFFFF;
         run($urandom_range(0, 3), 1'b0, 1'b0, $sformatf("rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
